pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_defs.sv | 39 +++
 rtl/pc_target_calc.sv | 69 ++++++
 rtl/pc_fetch_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_defs.sv
// -----------------------------------------------------------------------------
// pc_defs
// Shared definitions for the instruction-fetch PC controller.
//   - widths of the PC, branch immediate, jump index and exception vector
//   - reset vector (boot ROM entry)
//   - fetch FSM state encoding (2 bits)
//   - redirect source encoding used by the target calculator
//   - branch_offset(): sign-extended, word-scaled branch displacement
// -----------------------------------------------------------------------------
package pc_defs;

  localparam int unsigned PC_W     = 32;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned JIDX_W   = 26;
  localparam int unsigned EXC_PC_W = 32;

  localparam logic [PC_W-1:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [PC_W-1:0] INSN_BYTES   = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_BRANCH = 2'd1,
    RD_JUMP   = 2'd2,
    RD_JR     = 2'd3
  } redirect_src_e;

  // Branch displacement: the immediate counts instructions, so it is
  // sign-extended and scaled by 4 to become a byte offset.
  function automatic logic [PC_W-1:0] branch_offset(input logic [IMM_W-1:0] imm);
    return {{(PC_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// -----------------------------------------------------------------------------
// pc_target_calc
// Purely combinational redirect target calculator for the ID stage.
// Decides whether the instruction in ID redirects fetch and where to.
// Priority when several kinds are flagged: JR > J/JAL > taken branch.
//
// Ports
//   id_fire_i        : ID instruction advances this cycle (gates everything)
//   id_pc_i          : PC of the ID instruction
//   branch_en_i      : ID holds a conditional branch
//   branch_taken_i   : branch comparator result
//   imm16_i          : branch offset in instructions
//   jump_en_i        : J/JAL
//   jump_index_i     : 26-bit jump field
//   jr_en_i          : JR/JALR
//   jr_addr_i        : forwarded rs value (used unmodified)
//   redirect_valid_o : a redirect is live this cycle
//   redirect_pc_o    : target of the live redirect (0 when none)
// -----------------------------------------------------------------------------
module pc_target_calc
  import pc_defs::*;
(
  input  logic              id_fire_i,
  input  logic [PC_W-1:0]   id_pc_i,
  input  logic              branch_en_i,
  input  logic              branch_taken_i,
  input  logic [IMM_W-1:0]  imm16_i,
  input  logic              jump_en_i,
  input  logic [JIDX_W-1:0] jump_index_i,
  input  logic              jr_en_i,
  input  logic [PC_W-1:0]   jr_addr_i,
  output logic              redirect_valid_o,
  output logic [PC_W-1:0]   redirect_pc_o
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] jump_target;
  redirect_src_e   redirect_src;

  // Both branch and jump targets are relative to the delay-slot address.
  assign seq_pc        = id_pc_i + INSN_BYTES;
  assign branch_target = seq_pc + branch_offset(imm16_i);  // wraps modulo 2^32
  assign jump_target   = {seq_pc[PC_W-1:PC_W-4], jump_index_i, 2'b00};

  // NOTE: every variable assigned in an always_comb gets a default on its
  // first line, so no path can leave it unassigned and infer a latch.
  always_comb begin
    redirect_src = RD_NONE;
    if (id_fire_i) begin
      if (jr_en_i)                          redirect_src = RD_JR;
      else if (jump_en_i)                   redirect_src = RD_JUMP;
      else if (branch_en_i && branch_taken_i) redirect_src = RD_BRANCH;
    end
  end

  always_comb begin
    redirect_pc_o = '0;
    unique case (redirect_src)
      RD_JR:     redirect_pc_o = jr_addr_i;
      RD_JUMP:   redirect_pc_o = jump_target;
      RD_BRANCH: redirect_pc_o = branch_target;
      default:   redirect_pc_o = '0;
    endcase
  end

  assign redirect_valid_o = (redirect_src != RD_NONE);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
// Instruction-fetch PC controller: holds the fetch address, runs the
// BOOT/FETCH/HOLD request FSM and buffers a redirect that arrives while the
// PC cannot advance, so the delay-slot fetch always completes first.
//
// Build option
//   PC_EXC_EN : when defined, adds excpt_flush/excpt_pc; a flush in any state
//               loads excpt_pc, drops any buffered redirect and enters FETCH
//               regardless of stall. When undefined those ports do not exist.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   stall             : hazard-unit freeze
//   id_fire, id_pc    : ID instruction advances / its PC
//   branch_en, branch_taken, imm16 : conditional branch in ID
//   jump_en, jump_index            : J/JAL in ID
//   jr_en, jr_addr                 : JR/JALR in ID, forwarded rs
//   inst_ack          : instruction memory accepts the current request
//   excpt_flush, excpt_pc : exception redirect (PC_EXC_EN only)
//   pc                : fetch address
//   inst_req          : fetch request (asserted in FETCH)
//   if_fire           : fetch completed this cycle (FETCH and inst_ack)
//   redirect_pending  : buffered redirect target is valid
//   pc_misalign       : pc[1:0] != 0; fetch proceeds, flagged downstream
// -----------------------------------------------------------------------------
module pc_fetch_ctrl
  import pc_defs::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                id_fire,
  input  logic [PC_W-1:0]     id_pc,
  input  logic                branch_en,
  input  logic                branch_taken,
  input  logic [IMM_W-1:0]    imm16,
  input  logic                jump_en,
  input  logic [JIDX_W-1:0]   jump_index,
  input  logic                jr_en,
  input  logic [PC_W-1:0]     jr_addr,
  input  logic                inst_ack,
`ifdef PC_EXC_EN
  input  logic                excpt_flush,
  input  logic [EXC_PC_W-1:0] excpt_pc,
`endif
  output logic [PC_W-1:0]     pc,
  output logic                inst_req,
  output logic                if_fire,
  output logic                redirect_pending,
  output logic                pc_misalign
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            buf_valid_q, buf_valid_d;
  logic [PC_W-1:0] buf_pc_q, buf_pc_d;

  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic [PC_W-1:0] next_pc;
  logic            pc_advance;

  pc_target_calc u_target_calc (
    .id_fire_i        (id_fire),
    .id_pc_i          (id_pc),
    .branch_en_i      (branch_en),
    .branch_taken_i   (branch_taken),
    .imm16_i          (imm16),
    .jump_en_i        (jump_en),
    .jump_index_i     (jump_index),
    .jr_en_i          (jr_en),
    .jr_addr_i        (jr_addr),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc)
  );

  // ---------------------------------------------------------------------------
  // Next fetch address. A live redirect beats the buffer because it is the
  // younger control transfer (last writer wins).
  // ---------------------------------------------------------------------------
  always_comb begin
    next_pc = pc_q + INSN_BYTES;
`ifdef PC_EXC_EN
    if (excpt_flush)         next_pc = excpt_pc;
    else if (redirect_valid) next_pc = redirect_pc;
    else if (buf_valid_q)    next_pc = buf_pc_q;
`else
    if (redirect_valid)      next_pc = redirect_pc;
    else if (buf_valid_q)    next_pc = buf_pc_q;
`endif
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM: next state and the "pc loads next_pc" strobe.
  // BOOT never advances the PC, so the first request is for the reset vector
  // and an ack left over from before reset is ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_advance = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (inst_ack) begin
          // The fetch completes either way; a stall only freezes the PC.
          if (stall) state_d    = ST_HOLD;
          else       pc_advance = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          pc_advance = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
`ifdef PC_EXC_EN
    if (excpt_flush) begin
      state_d    = ST_FETCH;
      pc_advance = 1'b1;
    end
`endif
  end

  assign pc_d = pc_advance ? next_pc : pc_q;

  // ---------------------------------------------------------------------------
  // Redirect buffer: consumed on any PC advance (next_pc already used it or a
  // younger redirect); otherwise captures a live redirect, overwriting.
  // ---------------------------------------------------------------------------
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    if (pc_advance) begin
      buf_valid_d = 1'b0;
      buf_pc_d    = '0;
    end else if (redirect_valid) begin
      buf_valid_d = 1'b1;
      buf_pc_d    = redirect_pc;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  // NOTE: the buffered target is reset along with its valid bit; it feeds
  // next_pc directly, so an X there would reach the fetch address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VECTOR;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  assign pc               = pc_q;
  assign inst_req         = (state_q == ST_FETCH);
  assign if_fire          = (state_q == ST_FETCH) && inst_ack;
  assign redirect_pending = buf_valid_q;
  assign pc_misalign      = |pc_q[1:0];

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Self-checking bench for pc_fetch_ctrl. Expected fetch addresses are queued
// as each scenario is driven and compared whenever the DUT reports if_fire.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        id_fire = 1'b0;
  logic [31:0] id_pc = '0;
  logic        branch_en = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] imm16 = '0;
  logic        jump_en = 1'b0;
  logic [25:0] jump_index = '0;
  logic        jr_en = 1'b0;
  logic [31:0] jr_addr = '0;
  logic        inst_ack = 1'b0;
`ifdef PC_EXC_EN
  logic        excpt_flush = 1'b0;
  logic [31:0] excpt_pc = '0;
`endif
  logic [31:0] pc;
  logic        inst_req;
  logic        if_fire;
  logic        redirect_pending;
  logic        pc_misalign;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_pc;

  pc_fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .id_fire          (id_fire),
    .id_pc            (id_pc),
    .branch_en        (branch_en),
    .branch_taken     (branch_taken),
    .imm16            (imm16),
    .jump_en          (jump_en),
    .jump_index       (jump_index),
    .jr_en            (jr_en),
    .jr_addr          (jr_addr),
    .inst_ack         (inst_ack),
`ifdef PC_EXC_EN
    .excpt_flush      (excpt_flush),
    .excpt_pc         (excpt_pc),
`endif
    .pc               (pc),
    .inst_req         (inst_req),
    .if_fire          (if_fire),
    .redirect_pending (redirect_pending),
    .pc_misalign      (pc_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_id();
    id_fire = 1'b0; id_pc = '0; branch_en = 1'b0; branch_taken = 1'b0;
    imm16 = '0; jump_en = 1'b0; jump_index = '0; jr_en = 1'b0; jr_addr = '0;
  endtask

  task automatic drive_branch(input logic [31:0] pc_id, input logic [15:0] imm);
    id_fire = 1'b1; branch_en = 1'b1; branch_taken = 1'b1; id_pc = pc_id; imm16 = imm;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    inst_ack = 1'b1;  // ack during reset must not count as a fetch
    tick(); settle();
    tests_run++;
    if ({pc, inst_req, if_fire, redirect_pending, pc_misalign} !== {32'hBFC0_0000, 4'b0000}) begin
      tests_failed++;
      $display("FAIL reset_state: pc=%h req=%b fire=%b pend=%b mis=%b, required pc=bfc00000 and all flags 0",
               pc, inst_req, if_fire, redirect_pending, pc_misalign);
    end
    rst = 1'b0;
    settle();
    tests_run++;
    if ({inst_req, if_fire} !== 2'b00) begin
      tests_failed++;
      $display("FAIL boot_ignores_ack: req=%b fire=%b, required 0 0", inst_req, if_fire);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_boot_sequence();
    sb_q.push_back(32'hBFC0_0000);
    sb_q.push_back(32'hBFC0_0004);
    sb_q.push_back(32'hBFC0_0008);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      tests_run++;
      if ({inst_req, if_fire} !== 2'b11) begin
        tests_failed++;
        $display("FAIL boot_fetch%0d: req=%b fire=%b, required 1 1", i, inst_req, if_fire);
      end
      if (if_fire === 1'b1) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++; $display("FAIL boot_sb: unexpected fetch pc=%h, required none", pc);
        end else begin
          exp_pc = sb_q.pop_front();
          if (pc !== exp_pc) begin tests_failed++; $display("FAIL boot_sb: pc=%h, required %h", pc, exp_pc); end
        end
      end
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++; $display("FAIL boot_drain: %0d fetches missing, required 0", sb_q.size()); sb_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Taken branch with ack in the same cycle: target bfc00014-16 = bfc00004.
  task automatic test_branch_delay();
    sb_q.push_back(32'hBFC0_000C);
    sb_q.push_back(32'hBFC0_0004);
    sb_q.push_back(32'hBFC0_0008);
    for (int i = 0; i < 3; i++) begin
      tick(); clear_id(); inst_ack = 1'b1;
      if (i == 0) drive_branch(32'hBFC0_0010, 16'hFFFC);
      settle();
      if (i == 1) begin
        tests_run++;
        if (redirect_pending !== 1'b0) begin
          tests_failed++; $display("FAIL branch_no_pending: pend=%b, required 0", redirect_pending);
        end
      end
      if (if_fire === 1'b1) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++; $display("FAIL branch_sb: unexpected fetch pc=%h, required none", pc);
        end else begin
          exp_pc = sb_q.pop_front();
          if (pc !== exp_pc) begin tests_failed++; $display("FAIL branch_sb: pc=%h, required %h", pc, exp_pc); end
        end
      end
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++; $display("FAIL branch_drain: %0d fetches missing, required 0", sb_q.size()); sb_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Branch taken while memory withholds ack for 3 cycles. Target 0x1044.
  task automatic test_pending_redirect();
    sb_q.push_back(32'hBFC0_000C);
    sb_q.push_back(32'h0000_1044);
    for (int i = 0; i < 5; i++) begin
      tick(); clear_id();
      inst_ack = (i >= 3);
      if (i == 0) drive_branch(32'h0000_1000, 16'h0010);
      settle();
      if (i >= 1 && i <= 2) begin
        tests_run++;
        if ({redirect_pending, if_fire, inst_req, pc} !== {3'b101, 32'hBFC0_000C}) begin
          tests_failed++;
          $display("FAIL pending_hold%0d: pend=%b fire=%b req=%b pc=%h, required 1 0 1 bfc0000c",
                   i, redirect_pending, if_fire, inst_req, pc);
        end
      end
      if (i == 3 || i == 4) begin
        tests_run++;
        if (redirect_pending !== (i == 3)) begin
          tests_failed++; $display("FAIL pending_flag%0d: pend=%b, required %b", i, redirect_pending, (i == 3));
        end
      end
      if (if_fire === 1'b1) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++; $display("FAIL pending_sb: unexpected fetch pc=%h, required none", pc);
        end else begin
          exp_pc = sb_q.pop_front();
          if (pc !== exp_pc) begin tests_failed++; $display("FAIL pending_sb: pc=%h, required %h", pc, exp_pc); end
        end
      end
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++; $display("FAIL pending_drain: %0d fetches missing, required 0", sb_q.size()); sb_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Buffered branch (0x1044) overwritten by a later jump (0x48C).
  task automatic test_overwrite();
    sb_q.push_back(32'h0000_1048);
    sb_q.push_back(32'h0000_048C);
    for (int i = 0; i < 4; i++) begin
      tick(); clear_id();
      inst_ack = (i >= 2);
      if (i == 0) drive_branch(32'h0000_1000, 16'h0010);
      if (i == 1) begin
        id_fire = 1'b1; jump_en = 1'b1; id_pc = 32'h0000_1000; jump_index = 26'h000_0123;
      end
      settle();
      if (i == 1) begin
        tests_run++;
        if (redirect_pending !== 1'b1) begin
          tests_failed++; $display("FAIL overwrite_pend: pend=%b, required 1", redirect_pending);
        end
      end
      if (if_fire === 1'b1) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++; $display("FAIL overwrite_sb: unexpected fetch pc=%h, required none", pc);
        end else begin
          exp_pc = sb_q.pop_front();
          if (pc !== exp_pc) begin tests_failed++; $display("FAIL overwrite_sb: pc=%h, required %h", pc, exp_pc); end
        end
      end
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++; $display("FAIL overwrite_drain: %0d fetches missing, required 0", sb_q.size()); sb_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stall_hold();
    sb_q.push_back(32'h0000_0490);
    sb_q.push_back(32'h0000_0494);
    for (int i = 0; i < 5; i++) begin
      tick(); clear_id();
      inst_ack = 1'b1;
      stall    = (i <= 2);
      settle();
      if (i >= 1 && i <= 3) begin
        tests_run++;
        if ({inst_req, if_fire, pc} !== {2'b00, 32'h0000_0490}) begin
          tests_failed++;
          $display("FAIL stall_hold%0d: req=%b fire=%b pc=%h, required 0 0 00000490", i, inst_req, if_fire, pc);
        end
      end
      if (i == 4) begin
        tests_run++;
        if (inst_req !== 1'b1) begin
          tests_failed++; $display("FAIL stall_resume: req=%b, required 1", inst_req);
        end
      end
      if (if_fire === 1'b1) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++; $display("FAIL stall_sb: unexpected fetch pc=%h, required none", pc);
        end else begin
          exp_pc = sb_q.pop_front();
          if (pc !== exp_pc) begin tests_failed++; $display("FAIL stall_sb: pc=%h, required %h", pc, exp_pc); end
        end
      end
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++; $display("FAIL stall_drain: %0d fetches missing, required 0", sb_q.size()); sb_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // JR, J and a taken branch all flagged: JR wins, odd target sets misalign.
  task automatic test_jr_priority();
    sb_q.push_back(32'h0000_0498);
    sb_q.push_back(32'h8000_1002);
    sb_q.push_back(32'h8000_1006);
    for (int i = 0; i < 3; i++) begin
      tick(); clear_id(); inst_ack = 1'b1;
      if (i == 0) begin
        drive_branch(32'h0000_1000, 16'h0010);
        jump_en = 1'b1; jump_index = 26'h000_0123;
        jr_en = 1'b1; jr_addr = 32'h8000_1002;
      end
      settle();
      tests_run++;
      if (pc_misalign !== (i != 0)) begin
        tests_failed++; $display("FAIL jr_misalign%0d: mis=%b, required %b", i, pc_misalign, (i != 0));
      end
      if (if_fire === 1'b1) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++; $display("FAIL jr_sb: unexpected fetch pc=%h, required none", pc);
        end else begin
          exp_pc = sb_q.pop_front();
          if (pc !== exp_pc) begin tests_failed++; $display("FAIL jr_sb: pc=%h, required %h", pc, exp_pc); end
        end
      end
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++; $display("FAIL jr_drain: %0d fetches missing, required 0", sb_q.size()); sb_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Jump over branch with a nonzero region nibble, branch wrap past 2^32,
  // untaken branch, and a JR without id_fire.
  task automatic test_targets();
    sb_q.push_back(32'h8000_100A);
    sb_q.push_back(32'h9FFF_FFFC);
    sb_q.push_back(32'h0001_FFF0);
    sb_q.push_back(32'h0001_FFF4);
    sb_q.push_back(32'h0001_FFF8);
    for (int i = 0; i < 5; i++) begin
      tick(); clear_id(); inst_ack = 1'b1;
      case (i)
        0: begin
          drive_branch(32'h9000_0000, 16'h0010);
          jump_en = 1'b1; jump_index = 26'h3FF_FFFF;
        end
        1: drive_branch(32'hFFFF_FFF0, 16'h7FFF);
        2: begin drive_branch(32'h0000_1000, 16'h0010); branch_taken = 1'b0; end
        3: begin jr_en = 1'b1; jr_addr = 32'h1234_5678; end
        default: ;
      endcase
      settle();
      if (if_fire === 1'b1) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++; $display("FAIL targets_sb: unexpected fetch pc=%h, required none", pc);
        end else begin
          exp_pc = sb_q.pop_front();
          if (pc !== exp_pc) begin tests_failed++; $display("FAIL targets_sb: pc=%h, required %h", pc, exp_pc); end
        end
      end
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++; $display("FAIL targets_drain: %0d fetches missing, required 0", sb_q.size()); sb_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reset lands mid-request with a redirect in flight; late ack in BOOT.
  task automatic test_reset_mid_request();
    tick(); clear_id(); inst_ack = 1'b0;
    drive_branch(32'h0000_1000, 16'h0010);
    settle();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({pc, inst_req, if_fire, redirect_pending} !== {32'hBFC0_0000, 3'b000}) begin
      tests_failed++;
      $display("FAIL reset_async: pc=%h req=%b fire=%b pend=%b, required bfc00000 0 0 0",
               pc, inst_req, if_fire, redirect_pending);
    end
    tick(); tick();
    clear_id(); inst_ack = 1'b1;
    rst = 1'b0;
    settle();
    tests_run++;
    if ({inst_req, if_fire, redirect_pending} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_late_ack: req=%b fire=%b pend=%b, required 0 0 0", inst_req, if_fire, redirect_pending);
    end
    sb_q.push_back(32'hBFC0_0000);
    tick(); settle();
    if (if_fire === 1'b1) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++; $display("FAIL reset_sb: unexpected fetch pc=%h, required none", pc);
      end else begin
        exp_pc = sb_q.pop_front();
        if (pc !== exp_pc) begin tests_failed++; $display("FAIL reset_sb: pc=%h, required %h", pc, exp_pc); end
      end
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++; $display("FAIL reset_drain: %0d fetches missing, required 0", sb_q.size()); sb_q.delete();
    end
  endtask

`ifdef PC_EXC_EN
  // ---------------------------------------------------------------------------
  // Exception flush while stalled in HOLD with a buffered redirect.
  task automatic test_exception();
    sb_q.push_back(32'hBFC0_0004);
    for (int i = 0; i < 4; i++) begin
      tick(); clear_id();
      stall       = 1'b1;
      inst_ack    = (i == 0);
      excpt_flush = (i == 2);
      excpt_pc    = 32'hBFC0_0380;
      if (i == 1) drive_branch(32'h0000_1000, 16'h0010);
      settle();
      if (i == 2) begin
        tests_run++;
        if (redirect_pending !== 1'b1) begin
          tests_failed++; $display("FAIL exc_pend_before: pend=%b, required 1", redirect_pending);
        end
      end
      if (i == 3) begin
        tests_run++;
        if ({pc, redirect_pending, inst_req} !== {32'hBFC0_0380, 2'b01}) begin
          tests_failed++;
          $display("FAIL exc_flush: pc=%h pend=%b req=%b, required bfc00380 0 1", pc, redirect_pending, inst_req);
        end
      end
      if (if_fire === 1'b1) begin
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++; $display("FAIL exc_sb: unexpected fetch pc=%h, required none", pc);
        end else begin
          exp_pc = sb_q.pop_front();
          if (pc !== exp_pc) begin tests_failed++; $display("FAIL exc_sb: pc=%h, required %h", pc, exp_pc); end
        end
      end
    end
    excpt_flush = 1'b0;
    stall       = 1'b0;
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++; $display("FAIL exc_drain: %0d fetches missing, required 0", sb_q.size()); sb_q.delete();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_boot_sequence();
    test_branch_delay();
    test_pending_redirect();
    test_overwrite();
    test_stall_hold();
    test_jr_priority();
    test_targets();
    test_reset_mid_request();
`ifdef PC_EXC_EN
    test_exception();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
